// File: rtl/uart_tx_gpio.sv
// uart_tx_gpio: memory-mapped 8N1 UART transmitter, 1-byte buffer.
// clk/rst_n; addr,data_in,rd_strobe,wr_strobe in; data_out,uart_tx out.
module uart_tx_gpio #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        rd_strobe,
  input  logic [3:0]  wr_strobe,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] RELOAD =
    16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic [31:0] dout_q, dout_d;

  logic sel_data, sel_stat;
  logic wr_data, rd_data, rd_stat;
  logic busy, bit_end, load;
  logic accept, ovf_set;
  logic unused;

  assign unused = ^{addr[27:0], data_in[31:8]};

  assign sel_data = addr[31:28] == 4'h8;
  assign sel_stat = addr[31:28] == 4'h9;
  assign wr_data  = |wr_strobe && sel_data;
  assign rd_data  = rd_strobe && sel_data;
  assign rd_stat  = rd_strobe && sel_stat;

  assign busy    = state_q != IDLE;
  assign bit_end = cnt_q == 16'd0;

  // Buffer drains into the shifter from IDLE or
  // at the last cycle of a stop bit.
  assign load = full_q &&
    (state_q == IDLE ||
     (state_q == STOP && bit_end));

  // A write landing on the drain edge refills.
  assign accept  = wr_data && (!full_q || load);
  assign ovf_set = wr_data && full_q && !load;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          shift_d = buf_q;
          cnt_d   = RELOAD;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            state_d = START;
            shift_d = buf_q;
            cnt_d   = RELOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    dout_d = dout_q;
    if (accept) begin
      buf_d  = data_in[7:0];
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end
    // Set beats the read-to-clear.
    if (ovf_set) ovf_d = 1'b1;
    else if (rd_stat) ovf_d = 1'b0;
    unique case (1'b1)
      rd_stat: dout_d = {29'h0, ovf_q, full_q, busy};
      rd_data: dout_d = {24'h0, buf_q};
      default: dout_d = dout_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= 8'h0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      shift_q <= 8'h0;
      cnt_q   <= 16'h0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      dout_q  <= dout_d;
    end
  end

  assign uart_tx  = tx_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_uart_tx_gpio.sv
// tb_uart_tx_gpio: directed bench for uart_tx_gpio.
// CLKS_PER_BIT=4, frames sampled one cycle at a time.
module tb_uart_tx_gpio;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rd_strobe;
  logic [3:0]  wr_strobe;
  logic [31:0] data_out;
  logic        uart_tx;

  int n_cmp;
  int n_bad;
  logic [119:0] got;
  logic [31:0]  rd;

  uart_tx_gpio #(.CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .data_in   (data_in),
    .rd_strobe (rd_strobe),
    .wr_strobe (wr_strobe),
    .data_out  (data_out),
    .uart_tx   (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line, one entry per clock: start, d0..d7, stop.
  function automatic logic [39:0] frame(input logic [7:0] d);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i / 4;
      if (k == 0) f[i] = 1'b0;
      else if (k == 9) f[i] = 1'b1;
      else f[i] = d[k-1];
    end
    return f;
  endfunction

  task automatic write_reg(input logic [31:0] a,
                           input logic [7:0] d,
                           input logic [3:0] be);
    addr = a;
    data_in = {24'hABCDEF, d};
    wr_strobe = be;
    @(posedge clk);
    #1;
    wr_strobe = 4'h0;
  endtask

  task automatic read_reg(input logic [31:0] a,
                          output logic [31:0] d);
    addr = a;
    rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    rd_strobe = 1'b0;
    d = data_out;
  endtask

  task automatic collect(input int n);
    got = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got[i] = uart_tx;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tx got %b want 1", uart_tx);
    end
    n_cmp++;
    if (data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_dout got %h want 0", data_out);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_status got %h want 0", rd);
    end
    collect(20);
    n_cmp++;
    if (got[19:0] !== 20'hFFFFF) begin
      n_bad++;
      $display("FAIL reset_quiet got %h want fffff", got[19:0]);
    end
  endtask

  task automatic test_single_frame;
    write_reg(32'h8000_0000, 8'h55, 4'h1);
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL frame55_pre got %b want 1", uart_tx);
    end
    collect(40);
    n_cmp++;
    if (got[39:0] !== frame(8'h55)) begin
      n_bad++;
      $display("FAIL frame55 got %h want %h",
               got[39:0], frame(8'h55));
    end
    collect(1);
    n_cmp++;
    if (got[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL frame55_idle got %b want 1", got[0]);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL frame55_status got %h want 0", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [79:0] exp;
    exp = {frame(8'h3C), frame(8'hA1)};
    write_reg(32'h8123_4567, 8'hA1, 4'h8);
    @(posedge clk);
    #1;
    write_reg(32'h8000_0000, 8'h3C, 4'h4);
    collect(78);
    n_cmp++;
    if (got[77:0] !== exp[79:2]) begin
      n_bad++;
      $display("FAIL b2b got %h want %h",
               got[77:0], exp[79:2]);
    end
    collect(1);
    n_cmp++;
    if (got[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle got %b want 1", got[0]);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL b2b_status got %h want 0", rd);
    end
  endtask

  task automatic test_overflow;
    logic [39:0] f;
    addr = 32'h8000_0000;
    wr_strobe = 4'h2;
    data_in = 32'h11;
    @(posedge clk);
    #1;
    data_in = 32'h22;
    @(posedge clk);
    #1;
    data_in = 32'h33;
    @(posedge clk);
    #1;
    wr_strobe = 4'h0;
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h7) begin
      n_bad++;
      $display("FAIL ovf_status1 got %h want 7", rd);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h3) begin
      n_bad++;
      $display("FAIL ovf_status2 got %h want 3", rd);
    end
    f = frame(8'h11);
    collect(36);
    n_cmp++;
    if (got[35:0] !== f[39:4]) begin
      n_bad++;
      $display("FAIL ovf_frame11 got %h want %h",
               got[35:0], f[39:4]);
    end
    collect(40);
    n_cmp++;
    if (got[39:0] !== frame(8'h22)) begin
      n_bad++;
      $display("FAIL ovf_frame22 got %h want %h",
               got[39:0], frame(8'h22));
    end
    collect(12);
    n_cmp++;
    if (got[11:0] !== 12'hFFF) begin
      n_bad++;
      $display("FAIL ovf_no33 got %h want fff", got[11:0]);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL ovf_status3 got %h want 0", rd);
    end
    read_reg(32'h8000_0000, rd);
    n_cmp++;
    if (rd !== 32'h22) begin
      n_bad++;
      $display("FAIL ovf_txdata got %h want 22", rd);
    end
  endtask

  task automatic test_txdata_read;
    write_reg(32'h8000_0000, 8'h9E, 4'h1);
    read_reg(32'h8000_0000, rd);
    n_cmp++;
    if (rd !== 32'h9E) begin
      n_bad++;
      $display("FAIL txdata_rd got %h want 9e", rd);
    end
    // Hold-off: unmapped read keeps data_out.
    read_reg(32'h4000_0000, rd);
    n_cmp++;
    if (rd !== 32'h9E) begin
      n_bad++;
      $display("FAIL txdata_hold got %h want 9e", rd);
    end
    // Read and write in one cycle: old byte read, new accepted.
    addr = 32'h8000_0000;
    data_in = 32'h5A;
    wr_strobe = 4'hF;
    rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    wr_strobe = 4'h0;
    rd_strobe = 1'b0;
    n_cmp++;
    if (data_out !== 32'h9E) begin
      n_bad++;
      $display("FAIL rdwr_old got %h want 9e", data_out);
    end
    read_reg(32'h8000_0000, rd);
    n_cmp++;
    if (rd !== 32'h5A) begin
      n_bad++;
      $display("FAIL rdwr_new got %h want 5a", rd);
    end
    collect(100);
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL txdata_status got %h want 0", rd);
    end
  endtask

  task automatic test_unmapped;
    write_reg(32'h9000_0000, 8'hFF, 4'hF);
    write_reg(32'h1000_0000, 8'hFF, 4'hF);
    collect(16);
    n_cmp++;
    if (got[15:0] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL unmapped_line got %h want ffff", got[15:0]);
    end
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL unmapped_status got %h want 0", rd);
    end
    read_reg(32'h8000_0000, rd);
    n_cmp++;
    if (rd !== 32'h5A) begin
      n_bad++;
      $display("FAIL unmapped_txdata got %h want 5a", rd);
    end
  endtask

  task automatic test_reset_midframe;
    write_reg(32'h8000_0000, 8'hF0, 4'h1);
    read_reg(32'h8000_0000, rd);
    collect(17);
    n_cmp++;
    if (uart_tx !== 1'b0 || data_out !== 32'hF0) begin
      n_bad++;
      $display("FAIL mid_pre got tx=%b dout=%h want tx=0 dout=f0",
               uart_tx, data_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst_tx got %b want 1", uart_tx);
    end
    n_cmp++;
    if (data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst_dout got %h want 0", data_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_reg(32'h9000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_status got %h want 0", rd);
    end
    collect(50);
    n_cmp++;
    if (got[49:0] !== {50{1'b1}}) begin
      n_bad++;
      $display("FAIL mid_quiet got %h want all ones", got[49:0]);
    end
    read_reg(32'h8000_0000, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_buf got %h want 0", rd);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    addr = 32'h0;
    data_in = 32'h0;
    rd_strobe = 1'b0;
    wr_strobe = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_txdata_read;
    test_unmapped;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_gpio.md
UART_TX_GPIO -- requirements
Module: uart_tx_gpio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL give clock cycles per serial bit (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 addr  input  32  SHALL be the bus address; only addr[31:28] decoded: 0x8 = TXDATA, 0x9 = TXSTATUS.
REQ-005 data_in  input  32  SHALL be the bus write data; only [7:0] used.
REQ-006 rd_strobe  input  1  SHALL be the read request, sampled each clk.
REQ-007 wr_strobe  input  4  SHALL be the byte-lane write enables; any bit set = write.
REQ-008 data_out  output  32  SHALL be the registered read data.
REQ-009 uart_tx  output  1  SHALL be the serial line, idle high, registered.

Function
REQ-010 Write (|wr_strobe) to TXDATA with holding buffer empty SHALL load data_in[7:0] into a 1-byte buffer and mark it full at that edge.
REQ-011 Write to TXDATA with buffer full SHALL be dropped, buffer unchanged, sticky overflow flag set.
REQ-012 Writes to TXSTATUS or unmapped addresses SHALL have no effect.
REQ-013 Read of TXSTATUS SHALL load data_out = {29'h0, overflow, buf_full, busy} at the strobe edge (1-cycle latency).
REQ-014 Read of TXSTATUS SHALL clear overflow at the same edge; a simultaneous overflow set SHALL win.
REQ-015 Read of TXDATA SHALL load data_out = {24'h0, last byte accepted into buffer}.
REQ-016 With no read strobe or unmapped read, data_out SHALL hold its value.
REQ-017 busy SHALL be 1 whenever FSM is not IDLE.
REQ-018 FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE with buffer full: at next edge, move buffer to shift register, clear buf_full, enter START, drive uart_tx=0.
REQ-020 START SHALL hold uart_tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-021 DATA SHALL send 8 bits LSB first, each CLKS_PER_BIT cycles, tracked by a 3-bit index; after bit 7 enter STOP.
REQ-022 STOP SHALL hold uart_tx=1 for CLKS_PER_BIT cycles.
REQ-023 At STOP end with buffer full SHALL go directly to START with the next byte (no idle gap); else IDLE.
REQ-024 Frame SHALL be exactly 10*CLKS_PER_BIT cycles; baud counter reloads at every bit boundary without drift.
REQ-025 A TXDATA write in the same cycle the buffer is transferred to the shifter SHALL be accepted (buffer re-fills, no overflow).
REQ-026 A TXDATA write while the shifter is busy and the buffer empty SHALL be accepted without disturbing the current frame.
REQ-027 Simultaneous rd_strobe and wr_strobe SHALL both be serviced independently.

Reset
REQ-028 rst_n low SHALL immediately force: FSM IDLE, uart_tx=1, data_out=0, buf_full=0, overflow=0, baud counter=0, bit index=0, buffer=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, uart_tx=1 immediately; buffered byte discarded.
REQ-030 After rst_n deasserts, no transmission SHALL start until a TXDATA write.

Verification (CLKS_PER_BIT=4)
REQ-031 Write 0x55 to TXDATA when idle -> uart_tx low 1 cycle after write edge; bits 0,1,0,1,0,1,0,1 then stop, 4 cycles each, 40-cycle frame; busy then 0.
REQ-032 Write 0xA1 then 0x3C (buffer empty on 2nd) -> two frames back-to-back, 80 cycles total, uart_tx never idle between frames.
REQ-033 Write 0x11, 0x22, 0x33 on consecutive cycles -> 0x11 and 0x22 sent, 0x33 dropped; TXSTATUS read returns 0x7 during first frame, next read shows bit2 cleared.
REQ-034 Read TXSTATUS while idle after reset -> data_out = 0x0 one cycle after strobe; TXDATA read after writing 0x9E returns 0x9E.
REQ-035 Assert rst_n=0 during DATA bit 3 of 0xF0 -> uart_tx=1, busy=0, data_out=0 asynchronously; no further edges on uart_tx.
REQ-036 Write 0xFF with addr 0x9000_0000 or 0x1000_0000 -> no frame, buf_full stays 0.
